reg_scoreboard: RTL and testbench

//  Issue-hazard scoreboard for the 4-slot VLIW register file (slots: 0=LSU, 1=IXU1, 2=IXU2, 3=BRANCH).

---
 rtl/reg_scoreboard.sv | 135 +++++++++++++
 tb/tb_reg_scoreboard.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-hazard scoreboard for the 4-slot VLIW register file
// (slots 0=LSU, 1=IXU1, 2=IXU2, 3=BRANCH).
//
// The scoreboard keeps one busy bit per architectural register.
// - A bit is set when a bundle issues with that register as a destination.
// - A bit is cleared when the owning unit writes the register back.
// - A bundle is held back while any of its sources (RAW) or destinations
//   (WAW) is busy.
// - Hazard detection looks only at the registered busy bits. There is no
//   same-cycle writeback bypass, so a writeback unblocks a waiting bundle
//   one cycle later.
//
// Optional feature: define SCOREBOARD_PERF_EN to build the saturating
// stall_cycles counter. When it is undefined, stall_cycles is tied to zero
// and no counter flops exist.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bundle_valid,
  output logic                bundle_ready,
  input  logic [4*REG_W-1:0]  slot_rs1,
  input  logic [4*REG_W-1:0]  slot_rs2,
  input  logic [4*REG_W-1:0]  slot_rd,
  input  logic [3:0]          slot_rs1_en,
  input  logic [3:0]          slot_rs2_en,
  input  logic [3:0]          slot_rd_en,
  input  logic [3:0]          wb_valid,
  input  logic [4*REG_W-1:0]  wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                stall,
  output logic                dup_rd_err,
  output logic [PERF_W-1:0]   stall_cycles
);

  localparam int SLOTS = 4;

  logic [NUM_REGS-1:0] busy_p1;
  logic                dup_err_p1;
  logic                raw_hit;
  logic                waw_hit;
  logic                dup_hit;
  logic                issue;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_next;

  // Hazard check against the registered busy bits. Bit 0 is never set, so
  // register 0 can never raise a hazard.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_rs1_en[s] && busy_p1[slot_rs1[s*REG_W +: REG_W]]) raw_hit = 1'b1;
      if (slot_rs2_en[s] && busy_p1[slot_rs2[s*REG_W +: REG_W]]) raw_hit = 1'b1;
      if (slot_rd_en[s]  && busy_p1[slot_rd[s*REG_W +: REG_W]])  waw_hit = 1'b1;
    end
  end

  assign bundle_ready = ~flush & ~(raw_hit | waw_hit);
  assign issue        = bundle_valid & bundle_ready;
  assign stall        = bundle_valid & ~bundle_ready;

  // Per-register set and clear masks, plus duplicate-destination detection.
  // Using OR-ed masks means that repeated sets or repeated clears of one
  // register in the same cycle collapse to a single event.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    dup_hit  = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_rd_en[s]) set_mask[slot_rd[s*REG_W +: REG_W]] = 1'b1;
      if (wb_valid[s])   clr_mask[wb_rd[s*REG_W +: REG_W]]   = 1'b1;
      for (int t = s + 1; t < SLOTS; t++) begin
        if (slot_rd_en[s] && slot_rd_en[t] &&
            (slot_rd[s*REG_W +: REG_W] == slot_rd[t*REG_W +: REG_W]) &&
            (slot_rd[s*REG_W +: REG_W] != '0))
          dup_hit = 1'b1;
      end
    end
    set_mask[0] = 1'b0;
    clr_mask[0] = 1'b0;
  end

  // Next-state busy bits. Flush overrides everything. The set is applied
  // after the clear, so a same-cycle set and clear leaves the bit busy.
  always_comb begin
    if (flush) begin
      busy_next = '0;
    end else begin
      busy_next = (busy_p1 & ~clr_mask) | (issue ? set_mask : '0);
    end
    busy_next[0] = 1'b0;
  end

  // Busy-bit state and the sticky duplicate-destination flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1    <= '0;
      dup_err_p1 <= 1'b0;
    end else begin
      busy_p1 <= busy_next;
      if (issue && dup_hit) dup_err_p1 <= 1'b1;
    end
  end

  assign busy_vec   = busy_p1;
  assign dup_rd_err = dup_err_p1;

`ifdef SCOREBOARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_p1;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_p1 <= '0;
    end else if (stall) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign stall_cycles = stall_cnt_p1;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed vectors with a behavioural model
// and a per-cycle compare process. Define SCOREBOARD_PERF_EN to match the
// DUT build when the stall counter is enabled.
module tb_reg_scoreboard;

  localparam int NR = 32;
  localparam int RW = 5;
  localparam int PW = 32;

  logic          clk;
  logic          rst;
  logic          bundle_valid;
  logic          bundle_ready;
  logic [4*RW-1:0] slot_rs1, slot_rs2, slot_rd;
  logic [3:0]    slot_rs1_en, slot_rs2_en, slot_rd_en;
  logic [3:0]    wb_valid;
  logic [4*RW-1:0] wb_rd;
  logic          flush;
  logic [NR-1:0] busy_vec;
  logic          stall;
  logic          dup_rd_err;
  logic [PW-1:0] stall_cycles;

  reg_scoreboard #(.NUM_REGS(NR), .REG_W(RW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .slot_rs1(slot_rs1), .slot_rs2(slot_rs2), .slot_rd(slot_rd),
    .slot_rs1_en(slot_rs1_en), .slot_rs2_en(slot_rs2_en), .slot_rd_en(slot_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy_vec(busy_vec),
    .stall(stall), .dup_rd_err(dup_rd_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of pending registers plus a flag and a counter.
  bit          m_pending [NR];
  bit          m_dup;
  logic [PW-1:0] m_cnt;
  bit          started = 1'b0;

  function automatic int fld(input logic [4*RW-1:0] v, input int s);
    return int'(v[s*RW +: RW]);
  endfunction

  function automatic bit pend(input int r);
    return (r != 0) && m_pending[r];
  endfunction

  function automatic bit exp_ready();
    if (flush) return 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (slot_rs1_en[s] && pend(fld(slot_rs1, s))) return 1'b0;
      if (slot_rs2_en[s] && pend(fld(slot_rs2, s))) return 1'b0;
      if (slot_rd_en[s]  && pend(fld(slot_rd, s)))  return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int r = 1; r < NR; r++) v[r] = m_pending[r];
    return v;
  endfunction

  // Model update on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m_pending[r]) m_pending[r] = 1'b0;
      m_dup   = 1'b0;
      m_cnt   = '0;
      started = 1'b1;
    end else if (started) begin
      bit rdy;
      bit iss;
      rdy = exp_ready();
      iss = bundle_valid && rdy;
`ifdef SCOREBOARD_PERF_EN
      if (bundle_valid && !rdy && m_cnt != {PW{1'b1}}) m_cnt = m_cnt + 1;
`endif
      if (flush) begin
        foreach (m_pending[r]) m_pending[r] = 1'b0;
      end else begin
        for (int s = 0; s < 4; s++)
          if (wb_valid[s]) m_pending[fld(wb_rd, s)] = 1'b0;
        if (iss)
          for (int s = 0; s < 4; s++)
            if (slot_rd_en[s]) m_pending[fld(slot_rd, s)] = 1'b1;
        m_pending[0] = 1'b0;
      end
      if (iss)
        for (int s = 0; s < 4; s++)
          for (int t = s + 1; t < 4; t++)
            if (slot_rd_en[s] && slot_rd_en[t] && fld(slot_rd, s) == fld(slot_rd, t) &&
                fld(slot_rd, s) != 0)
              m_dup = 1'b1;
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      check("m_busy",  busy_vec, pend_vec());
      check("m_ready", 32'(bundle_ready), 32'(exp_ready()));
      check("m_stall", 32'(stall), 32'(bundle_valid && !exp_ready()));
      check("m_dup",   32'(dup_rd_err), 32'(m_dup));
      check("m_cnt",   stall_cycles, m_cnt);
    end
  end

  task automatic clr_in();
    bundle_valid = 1'b0; flush = 1'b0;
    slot_rs1 = '0; slot_rs2 = '0; slot_rd = '0;
    slot_rs1_en = '0; slot_rs2_en = '0; slot_rd_en = '0;
    wb_valid = '0; wb_rd = '0;
  endtask

  task automatic put_slot(input int s, input int rs1, input bit r1e,
                          input int rs2, input bit r2e, input int rd, input bit rde);
    slot_rs1[s*RW +: RW] = RW'(rs1); slot_rs1_en[s] = r1e;
    slot_rs2[s*RW +: RW] = RW'(rs2); slot_rs2_en[s] = r2e;
    slot_rd[s*RW +: RW]  = RW'(rd);  slot_rd_en[s]  = rde;
  endtask

  task automatic put_wb(input int s, input int rd);
    wb_valid[s] = 1'b1;
    wb_rd[s*RW +: RW] = RW'(rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef SCOREBOARD_PERF_EN
  localparam logic [31:0] CNT3 = 32'd3;
`else
  localparam logic [31:0] CNT3 = 32'd0;
`endif

  initial begin
    rst = 1'b1;
    clr_in();
    tick(); tick();
    rst = 1'b0;
    #2;
    check("rst_busy",  busy_vec, 32'h0);
    check("rst_ready", 32'(bundle_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dup",   32'(dup_rd_err), 32'd0);
    check("rst_cnt",   stall_cycles, 32'd0);

    // 1: LSU rd=5, then IXU1 reads r5 until writeback clears it
    put_slot(0, 0, 0, 0, 0, 5, 1); bundle_valid = 1'b1;
    tick(); clr_in();
    put_slot(1, 5, 1, 0, 0, 0, 0); bundle_valid = 1'b1;
    #2;
    check("t1_busy5",  busy_vec, 32'h20);
    check("t1_ready",  32'(bundle_ready), 32'd0);
    check("t1_stall",  32'(stall), 32'd1);
    tick(); put_wb(0, 5);
    #2;
    check("t1_wb_same_cycle_ready", 32'(bundle_ready), 32'd0);
    tick(); wb_valid = '0;
    #2;
    check("t1_cleared", busy_vec, 32'h0);
    check("t1_unblock", 32'(bundle_ready), 32'd1);
    tick(); clr_in();

    // 2: all-zero destinations and sources
    for (int s = 0; s < 4; s++) put_slot(s, 0, 1, 0, 0, 0, 1);
    bundle_valid = 1'b1;
    tick(); tick(); tick();
    #2;
    check("t2_busy0",  busy_vec, 32'h0);
    check("t2_ready",  32'(bundle_ready), 32'd1);
    clr_in();

    // 3: duplicate rd=7 in IXU1 and IXU2
    put_slot(1, 0, 0, 0, 0, 7, 1); put_slot(2, 0, 0, 0, 0, 7, 1); bundle_valid = 1'b1;
    #2;
    check("t3_ready", 32'(bundle_ready), 32'd1);
    tick(); clr_in();
    #2;
    check("t3_busy7", busy_vec, 32'h80);
    check("t3_dup",   32'(dup_rd_err), 32'd1);
    repeat (10) tick();
    check("t3_dup_held", 32'(dup_rd_err), 32'd1);

    // 4: busy 3 and 9, then flush with a valid bundle
    put_slot(0, 0, 0, 0, 0, 3, 1); put_slot(3, 0, 0, 0, 0, 9, 1); bundle_valid = 1'b1;
    tick(); clr_in();
    #2;
    check("t4_busy", busy_vec, 32'h288);
    flush = 1'b1; bundle_valid = 1'b1; put_slot(0, 0, 0, 0, 0, 10, 1);
    #2;
    check("t4_flush_ready", 32'(bundle_ready), 32'd0);
    tick(); clr_in();
    #2;
    check("t4_flushed", busy_vec, 32'h0);
    put_wb(0, 3);
    tick(); clr_in();
    #2;
    check("t4_late_wb", busy_vec, 32'h0);
    check("t4_dup_kept", 32'(dup_rd_err), 32'd1);

    // 5: same-cycle set and clear of r4 -> set wins; then WAW stall
    put_slot(0, 0, 0, 0, 0, 4, 1); bundle_valid = 1'b1;
    tick(); clr_in();
    put_wb(0, 4);
    tick(); clr_in();
    #2;
    check("t5_cleared", busy_vec, 32'h0);
    put_slot(1, 0, 0, 0, 0, 4, 1); bundle_valid = 1'b1; put_wb(2, 4);
    #2;
    check("t5_ready", 32'(bundle_ready), 32'd1);
    tick(); clr_in();
    #2;
    check("t5_set_wins", busy_vec, 32'h10);
    put_slot(2, 0, 0, 0, 0, 4, 1); bundle_valid = 1'b1;
    #2;
    check("t5_waw_ready", 32'(bundle_ready), 32'd0);
    check("t5_waw_stall", 32'(stall), 32'd1);
    tick(); clr_in();

    // 6: stall counter over 3 RAW cycles, then reset mid-stall
    rst = 1'b1;
    tick(); rst = 1'b0;
    put_slot(0, 0, 0, 0, 0, 4, 1); bundle_valid = 1'b1;
    tick(); clr_in();
    put_slot(3, 0, 0, 4, 1, 0, 0); bundle_valid = 1'b1;
    #2;
    check("t6_stall", 32'(stall), 32'd1);
    tick(); tick(); tick();
    #2;
    check("t6_cnt3", stall_cycles, CNT3);
    rst = 1'b1;
    tick();
    #2;
    check("t6_rst_busy",  busy_vec, 32'h0);
    check("t6_rst_dup",   32'(dup_rd_err), 32'd0);
    check("t6_rst_cnt",   stall_cycles, 32'd0);
    check("t6_rst_ready", 32'(bundle_ready), 32'd1);
    check("t6_rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick(); clr_in();
    put_wb(0, 4);
    tick(); clr_in();
    #2;
    check("t6_wb_noop", busy_vec, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
